// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct, alucontrol and mux-select encodings for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps aluop and R-type funct to alucontrol and flags unsupported funct codes
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);

  logic [2:0] fn_ctl;

  // decode funct, then let aluop override it for memory/branch arithmetic
  always_comb begin
    fn_ctl   = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  fn_ctl = ALU_ADD;
      FN_SUB:  fn_ctl = ALU_SUB;
      FN_AND:  fn_ctl = ALU_AND;
      FN_OR:   fn_ctl = ALU_OR;
      FN_SLT:  fn_ctl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
    alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                 aluop == ALUOP_FUNCT ? fn_ctl  : ALU_ADD;
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the multicycle MIPS datapath; `MC_BNE_EN adds bne
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  mc_state_t  state, next;
  logic [1:0] aluop;
  logic       funct_ok;
  logic       pcwrite, branch, bne_op;
  logic       irw, mw, rw, ill;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .funct_ok   (funct_ok)
  );

`ifdef MC_BNE_EN
  assign bne_op = op == OP_BNE;
`else
  assign bne_op = 1'b0;
`endif

  // state register; reset aborts any in-flight instruction back to fetch
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_FETCH;
    else       state <= next;

  // per-state control terms and next-state selection
  always_comb begin
    next     = S_FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    mw       = 1'b0;
    irw      = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    rw       = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    pcsrc    = PC_ALU;
    aluop    = ALUOP_ADD;
    ill      = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = SRCB_4;
        pcwrite = memready;
        irw     = memready;
        next    = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE: begin
            next = funct_ok ? S_RTYPEEX : S_FETCH;
            ill  = ~funct_ok;
          end
          OP_BEQ:  next = S_BEQEX;
          OP_ADDI: next = S_ADDIEX;
          OP_J:    next = S_JEX;
          default: begin
            next = bne_op ? S_BEQEX : S_FETCH;
            ill  = ~bne_op;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = op == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        next = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        rw       = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mw   = 1'b1;
        next = memready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        next    = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst = 1'b1;
        rw     = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = S_ADDIWB;
      end
      S_ADDIWB: rw = 1'b1;
      S_JEX: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: next = S_FETCH;
    endcase
  end

  assign pcen     = ~reset & (pcwrite | (branch & (bne_op ? ~zero : zero)));
  assign irwrite  = ~reset & irw;
  assign regwrite = ~reset & rw;
  assign memwrite = ~reset & mw;
  assign illegal  = ~reset & ill;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed per-cycle checks of the packed control word against hand-computed values
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       memready = 1'b1;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [15:0] ctl;
  int n_chk = 0;
  int n_pass = 0;

  localparam logic [15:0] FETCH   = 16'h9044;
  localparam logic [15:0] FSTALL  = 16'h0044;
  localparam logic [15:0] DEC     = 16'h00C4;
  localparam logic [15:0] DEC_ILL = 16'h00C5;
  localparam logic [15:0] MEMADR  = 16'h0184;
  localparam logic [15:0] MEMRD   = 16'h4004;
  localparam logic [15:0] MEMWB   = 16'h0604;
  localparam logic [15:0] MEMWR   = 16'h6004;
  localparam logic [15:0] RWB     = 16'h0A04;
  localparam logic [15:0] BEQ_T   = 16'h811C;
  localparam logic [15:0] BEQ_NT  = 16'h011C;
  localparam logic [15:0] ADDIWB  = 16'h0204;
  localparam logic [15:0] JEX     = 16'h8024;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  assign ctl = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input string tag, input logic mr, input logic z, input logic [15:0] exp);
    memready = mr;
    zero = z;
    #1;
    check(tag, ctl, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_forced", ctl, FSTALL);
    reset = 1'b0;
    op = 6'b100011;
    cyc("lw_fetch", 1, 0, FETCH);
    cyc("lw_dec", 1, 0, DEC);
    cyc("lw_memadr", 1, 0, MEMADR);
    cyc("lw_memrd", 1, 0, MEMRD);
    cyc("lw_memwb", 1, 0, MEMWB);
    op = 6'b101011;
    cyc("sw_fetch", 1, 0, FETCH);
    cyc("sw_dec", 1, 0, DEC);
    cyc("sw_memadr", 1, 0, MEMADR);
    cyc("sw_memwr0", 0, 0, MEMWR);
    cyc("sw_memwr1", 0, 0, MEMWR);
    cyc("sw_memwr2", 1, 0, MEMWR);
    op = 6'b000000;
    funct = 6'b101010;
    cyc("fetch_stall", 0, 0, FSTALL);
    cyc("slt_fetch", 1, 0, FETCH);
    cyc("slt_dec", 1, 0, DEC);
    cyc("slt_ex", 1, 0, 16'h010E);
    cyc("slt_wb", 1, 0, RWB);
    funct = 6'b100010;
    cyc("sub_fetch", 1, 0, FETCH);
    cyc("sub_dec", 1, 0, DEC);
    cyc("sub_ex", 1, 0, 16'h010C);
    cyc("sub_wb", 1, 0, RWB);
    funct = 6'b100101;
    cyc("or_fetch", 1, 0, FETCH);
    cyc("or_dec", 1, 0, DEC);
    cyc("or_ex", 1, 0, 16'h0102);
    cyc("or_wb", 1, 0, RWB);
    op = 6'b000100;
    cyc("beq1_fetch", 1, 1, FETCH);
    cyc("beq1_dec", 1, 1, DEC);
    cyc("beq1_ex", 1, 1, BEQ_T);
    cyc("beq0_fetch", 1, 0, FETCH);
    cyc("beq0_dec", 1, 0, DEC);
    cyc("beq0_ex", 1, 0, BEQ_NT);
    op = 6'b001000;
    cyc("addi_fetch", 1, 0, FETCH);
    cyc("addi_dec", 1, 0, DEC);
    cyc("addi_ex", 1, 0, MEMADR);
    cyc("addi_wb", 1, 0, ADDIWB);
    op = 6'b000010;
    cyc("j_fetch", 1, 0, FETCH);
    cyc("j_dec", 1, 0, DEC);
    cyc("j_ex", 1, 0, JEX);
    op = 6'b111111;
    cyc("ill_fetch", 1, 0, FETCH);
    cyc("ill_dec", 1, 0, DEC_ILL);
    op = 6'b000000;
    funct = 6'b000000;
    cyc("illfn_fetch", 1, 0, FETCH);
    cyc("illfn_dec", 1, 0, DEC_ILL);
    op = 6'b000101;
    cyc("bne_fetch", 1, 0, FETCH);
`ifdef MC_BNE_EN
    cyc("bne_dec", 1, 0, DEC);
    cyc("bne_ex", 1, 0, BEQ_T);
`else
    cyc("bne_dec_ill", 1, 0, DEC_ILL);
`endif
    op = 6'b100011;
    cyc("lws_fetch", 1, 0, FETCH);
    cyc("lws_dec", 1, 0, DEC);
    cyc("lws_memadr", 1, 0, MEMADR);
    cyc("lws_memrd0", 0, 0, MEMRD);
    cyc("lws_memrd1", 1, 0, MEMRD);
    memready = 1'b1;
    #1;
    check("lws_memwb", ctl, MEMWB);
    reset = 1'b1;
    #1;
    check("abort_reset", ctl, FSTALL);
    @(posedge clk);
    #1;
    check("abort_hold", ctl, FSTALL);
    reset = 1'b0;
    cyc("after_abort", 1, 0, FETCH);
    cyc("after_abort_dec", 1, 0, DEC);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS core: a Moore state machine that sequences a shared-memory multicycle datapath (one unified instruction/data memory, instruction register, ALU, register file) over 3–5 cycles per instruction. It sits inside the processor beside the datapath. It decodes `op`/`funct` from the instruction register and drives every mux select and write enable. It stalls on a memory-ready handshake so the unified memory may take multiple cycles.

## Interface
- No parameters.
- `clk  in  1`  core clock; all state changes on rising edge.
- `reset  in  1`  asynchronous, active-high; state → FETCH.
- `op  in  6`  instr[31:26] from instruction register.
- `funct  in  6`  instr[5:0] from instruction register.
- `zero  in  1`  ALU zero flag, same cycle.
- `memready  in  1`  memory access completes this cycle.
- `pcen  out  1`  PC register enable.
- `iord  out  1`  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite  out  1`  memory write strobe.
- `irwrite  out  1`  instruction register enable.
- `regdst  out  1`  write register: 0 = rt, 1 = rd.
- `memtoreg  out  1`  write data: 0 = ALUOut, 1 = Data reg.
- `regwrite  out  1`  register file write enable.
- `alusrca  out  1`  ALU A select: 0 = PC, 1 = A reg.
- `alusrcb  out  2`  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc  out  2`  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol  out  3`  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal  out  1`  one-cycle pulse on an unsupported op/funct.

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- R-type funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Unlisted values are illegal.
- States and outputs (unlisted outputs are 0; alucontrol is add unless stated):
  - FETCH: alusrcb=01. irwrite=pcen=memready. Advance to DECODE on memready, else hold.
  - DECODE: alusrca=0, alusrcb=11. Branches by op to:
    - MEMADR for lw/sw.
    - RTYPEEX for a legal R-type.
    - BEQEX for beq.
    - ADDIEX for addi.
    - JEX for j.
    - Otherwise: illegal=1 and go to FETCH (the instruction is a nop).
  - MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Go to MEMWB on memready, else hold.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
  - MEMWR: iord=1, memwrite=1. Held until memready, then → FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct → RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
  - BEQEX: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, pcen=zero → FETCH.
  - ADDIEX: alusrca=1, alusrcb=10 → ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
  - JEX: pcsrc=10, pcen=1 → FETCH.
- `pcen` = pcwrite | (branch & zero). pcwrite and branch are internal per-state terms.

## Timing
- Reset: state=FETCH asynchronously.
  - While `reset`=1, pcen, irwrite, regwrite, memwrite and illegal are forced to 0.
  - Every other output takes its FETCH value.
- Reset asserted mid-instruction aborts it; no partial write-back occurs after release.
- Cycle counts with memready always 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - An illegal instruction takes 2.
- Each memready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Outputs are combinational from state, plus `memready` (FETCH) and `zero` (BEQEX). There is no output register.
- `memwrite` stays stable and high through a MEMWR stall; `iord` stays high through MEMRD and MEMWR stalls.

## Configuration
- `MC_BNE_EN` defined: adds bne (op 000101).
  - DECODE routes bne to BEQEX.
  - In BEQEX, pcen = zero for beq and ~zero for bne.
  - bne takes 3 cycles.
- Undefined: op 000101 is illegal.

## Structure
- Package `mc_pkg` holds:
  - the state enum `mc_state_t`;
  - opcode and funct constants;
  - alucontrol constants;
  - `alusrcb` and `pcsrc` encodings.
- Sub-module `mc_aludec`: combinational aluop (00 add, 01 sub, 10 funct) + funct → alucontrol and funct-legal flag.
- The FSM next-state and output logic live in `mc_controller`.

## Test plan
- Reset high for 3 cycles, then low with memready=1, op=100011 → FETCH pcen=1, irwrite=1, alusrcb=01. Sequence FETCH→DECODE→MEMADR→MEMRD→MEMWB; MEMWB regwrite=1, memtoreg=1.
- sw with memready low for 2 cycles in MEMWR → memwrite high for 3 consecutive cycles, then FETCH. Total 6 cycles.
- R-type funct 101010 → alucontrol=111 in RTYPEEX; regwrite=1, regdst=1 in RTYPEWB.
- beq: zero=1 → pcen=1, pcsrc=01. zero=0 → pcen=0. Both return to FETCH after 3 cycles.
- op 111111 → illegal=1 for exactly one cycle in DECODE, then FETCH. No regwrite or memwrite is asserted.
- Reset asserted during MEMWB → regwrite drops immediately, state=FETCH. With `MC_BNE_EN`, op 000101 with zero=0 → pcen=1.
